hilo_unit: RTL
==============

// Module: hilo_unit
// PURPOSE
//  Architectural HI/LO register file and sequencer for the sequential signed 32x32 multiplier.
//  Sits between decode/control and the multiplier:
//   - latches the operands and pulses the multiplier's start;
//   - counts the multiplier's fixed latency, since the multiplier has no done flag;
//   - captures the multiplier's HI/LO outputs into architectural HI/LO;
//   - serves mfhi/mflo/mthi/mtlo and stalls the pipeline while a multiply is in flight.
// PARAMETERS
//  MULT_LATENCY  36  edges from the edge that samples mul_start=1 to the edge on which mul_hi/mul_lo update
//  CNT_W         6   width of wait counter; must satisfy 2**CNT_W > MULT_LATENCY
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  mult_req   in   1   multiply instruction present; held by pipeline while stall=1
//  op_a       in   32  multiplier operand (rs)
//  op_b       in   32  multiplicand operand (rt)
//  mthi       in   1   write wdata to HI
//  mtlo       in   1   write wdata to LO
//  wdata      in   32  mthi/mtlo write data
//  mfhi       in   1   read HI onto rdata
//  mflo       in   1   read LO onto rdata
//  mul_a      out  32  to multiplier A (registered, held stable)
//  mul_b      out  32  to multiplier B (registered, held stable)
//  mul_start  out  1   to multiplier start, one-cycle pulse
//  mul_hi     in   32  from multiplier HI
//  mul_lo     in   32  from multiplier LO
//  rdata      out  32  combinational read data
//  stall      out  1   combinational; freeze pipeline this cycle
//  busy       out  1   registered; 1 in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; hi_r, lo_r, mul_a, mul_b = 0; mul_start=0, busy=0; rdata=0, stall=0.
//   Reset mid-operation aborts the operation with no capture. Multiplier shares this reset.
//  FSM states: IDLE -> ISSUE -> WAIT -> CAPTURE -> IDLE.
//  IDLE:
//   - mult_req=1: at the edge, mul_a<=op_a, mul_b<=op_b, go to ISSUE; stall=0 in the accepting cycle.
//   - mthi/mtlo apply at the edge. mthi+mtlo together write both registers.
//   - mt* coincident with an accepted mult_req is still applied; the later capture overwrites it.
//  ISSUE: mul_start=1 for exactly this cycle; cnt<=0; next state WAIT.
//  WAIT: cnt<=cnt+1 each cycle. Exit to CAPTURE when cnt==MULT_LATENCY-2, i.e. after MULT_LATENCY-1 WAIT cycles.
//  CAPTURE:
//   - mul_hi/mul_lo are valid in this cycle; hi_r<=mul_hi, lo_r<=mul_lo at the edge; next state IDLE.
//   - Multiplier is already back in its idle state, so back-to-back multiplies are legal.
//  Timing: accept at cycle T, ISSUE T+1, WAIT T+2..T+MULT_LATENCY, CAPTURE T+MULT_LATENCY+1.
//   New HI/LO readable from T+MULT_LATENCY+2 (T+38 at default).
//  stall=1 when busy=1 and any of mult_req, mthi, mtlo, mfhi, mflo is asserted; otherwise stall=0.
//   Stalled requests have no side effect.
//  rdata = mfhi ? hi_r : mflo ? lo_r : 0. mfhi has priority if both are asserted.
//   rdata is don't-care while stall=1.
//  mul_a and mul_b change only on acceptance; held from ISSUE through CAPTURE because the multiplier samples
//   them one cycle after start.
// CONFIGURATION
//  HILO_FWD_EN defined:
//   - In CAPTURE, mfhi/mflo are not stalled: rdata = mfhi ? mul_hi : mul_lo.
//   - mthi/mtlo and mult_req still stall in CAPTURE.
//   - Saves one cycle per dependent read.
//  HILO_FWD_EN undefined: every request stalls through CAPTURE, as described above.
// TESTING
//  1) reset, then mfhi and mflo -> rdata=0, stall=0, busy=0; reset held -> mul_start stays 0.
//  2) mult_req op_a=7, op_b=6 at T, mfhi held from T+1:
//     mul_start high only at T+1; stall high T+1..T+37;
//     rdata=0 at T+38; mflo -> 42.
//  3) op_a=32'hFFFFFFFD (-3), op_b=5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1.
//     op_a=32'h80000000, op_b=32'hFFFFFFFF -> HI=0, LO=32'h80000000.
//  4) mthi+mtlo with wdata=32'h12345678 in IDLE -> both read back 32'h12345678.
//     mtlo during WAIT -> stall=1, LO unchanged.
//  5) Back-to-back: second mult_req (3*4) held during the first multiply (7*6):
//     accepted at T+38; LO=12 readable at T+76.
//     Reset asserted during WAIT: IDLE, busy=0, HI/LO=0 next cycle, no later capture.
//  6) With HILO_FWD_EN: mflo at T+37 -> stall=0, rdata=42.
//     Without HILO_FWD_EN: mflo at T+37 -> stall=1.

Source files
------------

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register file and sequencer for the sequential signed 32x32 multiplier
// Optional build macro: HILO_FWD_EN (mfhi/mflo read the multiplier outputs directly during CAPTURE)
module hilo_unit #(
   parameter int MULT_LATENCY = 36,
   parameter int CNT_W        = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mult_req,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        mfhi,
   input  logic        mflo,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_start,
   input  logic [31:0] mul_hi,
   input  logic [31:0] mul_lo,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPTURE
   } state_t;

   // WAIT holds for MULT_LATENCY-1 cycles; the counter starts at 0 on entry.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LATENCY - 2);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;
   logic [31:0]      mul_a_q;
   logic [31:0]      mul_b_q;
   logic             mul_start_q;
   logic             busy_q;
   logic             rd_fwd;

   // Sequencer: accept, pulse start, count the fixed latency, capture HI/LO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_start_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         mul_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // Register writes still land when a multiply is accepted in the
               // same cycle; the capture later overwrites them.
               if (mthi) hi_q <= wdata;
               if (mtlo) lo_q <= wdata;
               if (mult_req) begin
                  mul_a_q     <= op_a;
                  mul_b_q     <= op_b;
                  mul_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               hi_q    <= mul_hi;
               lo_q    <= mul_lo;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Stall and read mux; in CAPTURE reads may bypass straight from the multiplier.
   always_comb begin
      rd_fwd = 1'b0;
`ifdef HILO_FWD_EN
      rd_fwd = (state_q == S_CAPTURE);
`endif
      stall = busy_q & (mult_req | mthi | mtlo | ((mfhi | mflo) & ~rd_fwd));
      if (rd_fwd && mfhi)      rdata = mul_hi;
      else if (rd_fwd && mflo) rdata = mul_lo;
      else if (mfhi)           rdata = hi_q;
      else if (mflo)           rdata = lo_q;
      else                     rdata = '0;
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign mul_start = mul_start_q;
   assign busy      = busy_q;

endmodule
